// File: rtl/load_port_pkg.sv
// Shared constants for the load-port arbiter: block-address slicing and ORL entry layout.
package load_port_pkg;

   localparam int unsigned BLK_HI        = 15;
   localparam int unsigned BLK_LO        = 2;
   localparam int unsigned ENT_SQUASHED  = 0;
   localparam int unsigned ENT_DEMAND    = 1;
   localparam int unsigned ENT_ADDR_LO   = 2;
   localparam int unsigned ENT_ADDR_HI   = 17;
   localparam int unsigned ENT_W         = 18;
   localparam int unsigned ORL_DEPTH_DEF = 4;

   localparam logic [15:0] BLK_MASK = 16'((32'(1) << (BLK_HI + 1)) - (32'(1) << BLK_LO));

   function automatic logic blockMatch(input logic [15:0] a, input logic [15:0] b);
      return ((a ^ b) & BLK_MASK) == 16'h0000;
   endfunction

   function automatic logic [ENT_W-1:0] makeEntry(input logic [15:0] addr, input logic demand,
                                                  input logic squashed);
      return {addr, demand, squashed};
   endfunction

endpackage

// File: rtl/orl_fifo.sv
// Outstanding request list: in-order circular buffer with per-entry block match against
// two lookup addresses, demand-merge and prefetch-squash controls.
module orl_fifo
   import load_port_pkg::*;
#(
   parameter int unsigned DEPTH = ORL_DEPTH_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [ENT_W-1:0] pushEntry,
   input  logic             pop,
   input  logic [15:0]      lookupA,
   input  logic [15:0]      lookupB,
   input  logic [DEPTH-1:0] setDemand,
   input  logic             squashAll,
   output logic [ENT_W-1:0] headEntry,
   output logic             empty,
   output logic             full,
   output logic [DEPTH-1:0] matchA,
   output logic [DEPTH-1:0] matchB,
   output logic [DEPTH-1:0] demandVec
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [ENT_W-1:0] entries [DEPTH];
   logic [PW-1:0]    headPtr;
   logic [PW-1:0]    tailPtr;
   logic [PW:0]      count;
   logic [DEPTH-1:0] live;

   always_comb begin
      live      = '0;
      matchA    = '0;
      matchB    = '0;
      demandVec = '0;
      for (int i = 0; i < DEPTH; i++) begin
         // Slot i is live when its distance from the head is below the occupancy.
         live[i]      = {1'b0, PW'(i) - headPtr} < count;
         matchA[i]    = live[i] & blockMatch(entries[i][ENT_ADDR_HI:ENT_ADDR_LO], lookupA);
         matchB[i]    = live[i] & blockMatch(entries[i][ENT_ADDR_HI:ENT_ADDR_LO], lookupB);
         demandVec[i] = entries[i][ENT_DEMAND];
      end
   end

   assign headEntry = entries[headPtr];
   assign empty     = count == '0;
   assign full      = count == (PW + 1)'(DEPTH);

   always_ff @(posedge clk) begin
      if (reset) begin
         headPtr <= '0;
         tailPtr <= '0;
         count   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            entries[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (live[i]) begin
               // A merging demand keeps its entry alive through a concurrent flush.
               if (setDemand[i]) begin
                  entries[i][ENT_DEMAND]   <= 1'b1;
                  entries[i][ENT_SQUASHED] <= 1'b0;
               end else if (squashAll && !entries[i][ENT_DEMAND]) begin
                  entries[i][ENT_SQUASHED] <= 1'b1;
               end
            end
         end
         if (push) begin
            entries[tailPtr] <= pushEntry;
            tailPtr          <= tailPtr + PW'(1);
         end
         if (pop) begin
            headPtr <= headPtr + PW'(1);
         end
         count <= count + (PW + 1)'(push) - (PW + 1)'(pop);
      end
   end

endmodule

// File: rtl/load_port_arbiter.sv
// Shares the memory load port between demand misses and prefetches, merging and dropping
// requests against the outstanding request list and labelling in-order responses.
module load_port_arbiter
   import load_port_pkg::*;
#(
   parameter int unsigned ORL_DEPTH = ORL_DEPTH_DEF,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             dem_valid,
   input  logic [15:0]      dem_addr,
   output logic             dem_accept,
   input  logic             pf_valid,
   input  logic [15:0]      pf_addr,
   output logic             pf_accept,
   input  logic             pf_flush,
   output logic             mem_enable,
   output logic [15:0]      mem_addr,
   input  logic             mem_ready,
   output logic             resp_valid,
   output logic [15:0]      resp_addr,
   output logic             resp_demand,
   output logic [CNT_W-1:0] pf_issued_cnt,
   output logic [CNT_W-1:0] pf_useful_cnt,
   output logic             orl_error
);

   logic [ENT_W-1:0]     headEntry;
   logic [ENT_W-1:0]     pushEntry;
   logic                 empty;
   logic                 full;
   logic [ORL_DEPTH-1:0] demMatch;
   logic [ORL_DEPTH-1:0] pfMatch;
   logic [ORL_DEPTH-1:0] demandVec;
   logic [ORL_DEPTH-1:0] setDemand;
   logic                 popNow;
   logic                 space;
   logic                 demHit;
   logic                 demIssue;
   logic                 pfHit;
   logic                 pfIssue;
   logic                 push;
   logic                 usefulHit;
   logic                 headMerge;
   logic [CNT_W-1:0]     pfIssuedQ;
   logic [CNT_W-1:0]     pfUsefulQ;
   logic                 orlErrorQ;

   always_comb begin
      popNow    = mem_ready & ~empty;
      // A full list still has room when the head leaves in the same cycle.
      space     = ~full | popNow;
      demHit    = dem_valid & (|demMatch);
      demIssue  = dem_valid & ~demHit & space;
      pfHit     = pf_valid & ((|pfMatch) | (dem_valid & blockMatch(pf_addr, dem_addr)));
      pfIssue   = pf_valid & ~pfHit & ~demIssue & space;
      push      = demIssue | pfIssue;
      usefulHit = demHit & (|(demMatch & ~demandVec));
      headMerge = dem_valid & ~empty & blockMatch(headEntry[ENT_ADDR_HI:ENT_ADDR_LO], dem_addr);
      setDemand = {ORL_DEPTH{dem_valid}} & demMatch;

      dem_accept = demHit | demIssue;
      pf_accept  = pfHit | pfIssue;
      mem_enable = push;
      mem_addr   = demIssue ? dem_addr : (pfIssue ? pf_addr : 16'h0000);
      pushEntry  = demIssue ? makeEntry(dem_addr, 1'b1, 1'b0)
                            : makeEntry(pf_addr, 1'b0, pf_flush);

      resp_valid  = popNow & ~headEntry[ENT_SQUASHED];
      resp_addr   = popNow ? headEntry[ENT_ADDR_HI:ENT_ADDR_LO] : 16'h0000;
      resp_demand = popNow & (headEntry[ENT_DEMAND] | headMerge);
   end

   orl_fifo #(
      .DEPTH(ORL_DEPTH)
   ) u_orl (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pushEntry (pushEntry),
      .pop       (popNow),
      .lookupA   (dem_addr),
      .lookupB   (pf_addr),
      .setDemand (setDemand),
      .squashAll (pf_flush),
      .headEntry (headEntry),
      .empty     (empty),
      .full      (full),
      .matchA    (demMatch),
      .matchB    (pfMatch),
      .demandVec (demandVec)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         pfIssuedQ <= '0;
         pfUsefulQ <= '0;
         orlErrorQ <= 1'b0;
      end else begin
         if (pfIssue && pfIssuedQ != '1) begin
            pfIssuedQ <= pfIssuedQ + CNT_W'(1);
         end
         if (usefulHit && pfUsefulQ != '1) begin
            pfUsefulQ <= pfUsefulQ + CNT_W'(1);
         end
         if (mem_ready && empty) begin
            orlErrorQ <= 1'b1;
         end
      end
   end

   assign pf_issued_cnt = pfIssuedQ;
   assign pf_useful_cnt = pfUsefulQ;
   assign orl_error     = orlErrorQ;

endmodule

// File: tb/tb_load_port_arbiter.sv
// Directed bench for load_port_arbiter: expected issues and responses go into queues that a
// negedge monitor drains whenever the DUT strobes the load port or a response is returned.
module tb_load_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        dem_valid;
   logic [15:0] dem_addr;
   logic        dem_accept;
   logic        pf_valid;
   logic [15:0] pf_addr;
   logic        pf_accept;
   logic        pf_flush;
   logic        mem_enable;
   logic [15:0] mem_addr;
   logic        mem_ready;
   logic        resp_valid;
   logic [15:0] resp_addr;
   logic        resp_demand;
   logic [15:0] pf_issued_cnt;
   logic [15:0] pf_useful_cnt;
   logic        orl_error;

   int nTotal = 0;
   int nPass  = 0;

   logic [15:0] issueQ [$];
   logic [17:0] respQ  [$];

   load_port_arbiter #(
      .ORL_DEPTH(4),
      .CNT_W    (16)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .dem_valid    (dem_valid),
      .dem_addr     (dem_addr),
      .dem_accept   (dem_accept),
      .pf_valid     (pf_valid),
      .pf_addr      (pf_addr),
      .pf_accept    (pf_accept),
      .pf_flush     (pf_flush),
      .mem_enable   (mem_enable),
      .mem_addr     (mem_addr),
      .mem_ready    (mem_ready),
      .resp_valid   (resp_valid),
      .resp_addr    (resp_addr),
      .resp_demand  (resp_demand),
      .pf_issued_cnt(pf_issued_cnt),
      .pf_useful_cnt(pf_useful_cnt),
      .orl_error    (orl_error)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nTotal++;
      if (act === exp) nPass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitor: compares every load-port strobe and every returned response in order.
   always @(negedge clk) begin
      if (mem_enable === 1'b1) begin
         if (issueQ.size() == 0) check("unexpected mem_enable", 32'(mem_addr), 32'hFFFF_FFFF);
         else check("mem_addr", 32'(mem_addr), 32'(issueQ.pop_front()));
      end
      if (mem_ready === 1'b1) begin
         if (respQ.size() == 0) check("unexpected response", 32'(resp_addr), 32'hFFFF_FFFF);
         else check("resp {valid,addr,demand}", 32'({resp_valid, resp_addr, resp_demand}),
                    32'(respQ.pop_front()));
      end
   end

   // Drives one cycle starting just after posedge; returns just after the next posedge.
   task automatic step(input logic dv, input logic [15:0] da, input logic pv,
                       input logic [15:0] pa, input logic fl, input logic mr,
                       input logic eDa, input logic ePa, input logic eIss,
                       input logic [15:0] eMa, input logic [17:0] eResp);
      dem_valid = dv;
      dem_addr  = da;
      pf_valid  = pv;
      pf_addr   = pa;
      pf_flush  = fl;
      mem_ready = mr;
      if (eIss) issueQ.push_back(eMa);
      if (mr) respQ.push_back(eResp);
      @(negedge clk);
      check("dem_accept", 32'(dem_accept), 32'(eDa));
      check("pf_accept", 32'(pf_accept), 32'(ePa));
      check("mem_enable", 32'(mem_enable), 32'(eIss));
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 18'h0);
   endtask

   task automatic doReset();
      reset     = 1'b1;
      dem_valid = 1'b0;
      dem_addr  = 16'h0;
      pf_valid  = 1'b0;
      pf_addr   = 16'h0;
      pf_flush  = 1'b0;
      mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset mem_enable", 32'(mem_enable), 32'h0);
      check("reset mem_addr", 32'(mem_addr), 32'h0);
      check("reset resp_valid", 32'(resp_valid), 32'h0);
      check("reset resp_addr", 32'(resp_addr), 32'h0);
      check("reset resp_demand", 32'(resp_demand), 32'h0);
      check("reset pf_issued_cnt", 32'(pf_issued_cnt), 32'h0);
      check("reset pf_useful_cnt", 32'(pf_useful_cnt), 32'h0);
      check("reset orl_error", 32'(orl_error), 32'h0);
      reset = 1'b0;
   endtask

   initial begin
      doReset();

      // Lone demand miss issues immediately and is answered as a demand.
      step(1'b1, 16'h0104, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0104, 18'h0);
      step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0,
           {1'b1, 16'h0104, 1'b1});

      // Demand merges into an in-flight prefetch of the same block.
      step(1'b0, 16'h0, 1'b1, 16'h0200, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0200, 18'h0);
      idle();
      step(1'b1, 16'h0203, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 18'h0);
      step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0,
           {1'b1, 16'h0200, 1'b1});
      check("pf_issued after merge", 32'(pf_issued_cnt), 32'd1);
      check("pf_useful after merge", 32'(pf_useful_cnt), 32'd1);

      // Demand wins the port; the prefetch follows next cycle, responses keep order.
      step(1'b1, 16'h0040, 1'b1, 16'h0080, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0040, 18'h0);
      step(1'b0, 16'h0, 1'b1, 16'h0080, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0080, 18'h0);
      step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0,
           {1'b1, 16'h0040, 1'b1});
      step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0,
           {1'b1, 16'h0080, 1'b0});

      // Prefetch colliding with a same-cycle demand block is dropped.
      step(1'b1, 16'h6000, 1'b1, 16'h6002, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h6000, 18'h0);
      step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0,
           {1'b1, 16'h6000, 1'b1});

      // Full list: demand stalls until a response frees a slot in the same cycle.
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 16'h0, 1'b1, 16'h1000 + 16'(i * 16), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
              16'h1000 + 16'(i * 16), 18'h0);
      end
      step(1'b1, 16'h0300, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 18'h0);
      step(1'b1, 16'h0300, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 18'h0);
      step(1'b1, 16'h0300, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0300,
           {1'b1, 16'h1000, 1'b0});
      step(1'b0, 16'h0, 1'b1, 16'h2000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 18'h0);
      step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0,
           {1'b1, 16'h1010, 1'b0});
      step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0,
           {1'b1, 16'h1020, 1'b0});
      step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0,
           {1'b1, 16'h1030, 1'b0});
      step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0,
           {1'b1, 16'h0300, 1'b1});
      check("pf_issued after fill", 32'(pf_issued_cnt), 32'd6);

      // Flush squashes an in-flight prefetch and one issued in the flush cycle.
      step(1'b0, 16'h0, 1'b1, 16'h4000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h4000, 18'h0);
      step(1'b0, 16'h0, 1'b1, 16'h4010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h4010, 18'h0);
      step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0,
           {1'b0, 16'h4000, 1'b0});
      step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0,
           {1'b0, 16'h4010, 1'b0});

      // A demand merged after a flush revives its entry; duplicate prefetch is dropped.
      step(1'b0, 16'h0, 1'b1, 16'h5000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h5000, 18'h0);
      step(1'b0, 16'h0, 1'b1, 16'h5010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h5010, 18'h0);
      step(1'b0, 16'h0, 1'b1, 16'h5003, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 18'h0);
      step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 18'h0);
      step(1'b1, 16'h5012, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 18'h0);
      step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0,
           {1'b0, 16'h5000, 1'b0});
      step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0,
           {1'b1, 16'h5010, 1'b1});
      check("pf_issued before reset", 32'(pf_issued_cnt), 32'd10);
      check("pf_useful before reset", 32'(pf_useful_cnt), 32'd2);
      check("orl_error clean", 32'(orl_error), 32'h0);

      // Response with an empty list raises the sticky error; reset clears everything.
      doReset();
      step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0,
           {1'b0, 16'h0000, 1'b0});
      check("orl_error set", 32'(orl_error), 32'h1);
      idle();
      check("orl_error held", 32'(orl_error), 32'h1);
      doReset();

      check("issue queue drained", 32'(issueQ.size()), 32'd0);
      check("response queue drained", 32'(respQ.size()), 32'd0);
      $display("%0d/%0d checks passed", nPass, nTotal);
      $finish;
   end

endmodule
